// File: rtl/serial_set_cond_pkg.sv
// Shared types for the WISC set-condition evaluator.
package wisc_setcond_pkg;

    typedef enum logic [1:0] {
        SEQ = 2'b00,
        SLT = 2'b01,
        SLE = 2'b10,
        SCO = 2'b11
    } setop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ssc_state_t;

    // Signed less-than from the sign of (a - b) corrected by overflow.
    function automatic logic lt_from_flags(input logic sign, input logic v);
        return sign ^ v;
    endfunction

endpackage

// File: rtl/serial_set_cond_add_slice.sv
// STEP-bit combinational ripple adder slice; also exposes the carry into its MSB.
module serial_add_slice #(
    parameter int unsigned STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    input  logic            cin,
    output logic [STEP-1:0] sum,
    output logic            cout,
    output logic            c_msb
);

    logic [STEP:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(STEP); i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = carry[STEP];
    assign c_msb = carry[STEP-1];

endmodule

// File: rtl/serial_set_cond.sv
// Multi-cycle SEQ/SLT/SLE/SCO evaluator: operands are consumed LSB-first,
// STEP bits per cycle, through one serial add/subtract slice.
module serial_set_cond
    import wisc_setcond_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned SLICES = WIDTH / STEP;
    localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned LAST   = SLICES - 1;

    ssc_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    setop_t           op_q, op_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_d, out_valid_d, busy_d;
    logic [WIDTH-1:0] out_data_d;

    logic [STEP-1:0]  s_sum;
    logic             s_cout, s_cmsb;
    logic             res_bit;

    serial_add_slice #(.STEP(STEP)) u_slice (
        .a     (a_q[STEP-1:0]),
        .b     (b_q[STEP-1:0]),
        .cin   (carry_q),
        .sum   (s_sum),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // Result bit from the flags of the final slice; only meaningful on the last RUN cycle.
    always_comb begin
        logic zero_fin;
        logic ovf;
        logic lt;
        zero_fin = zero_q & (s_sum == '0);
        ovf      = s_cmsb ^ s_cout;
        lt       = lt_from_flags(s_sum[STEP-1], ovf);
        res_bit  = 1'b0;
        case (op_q)
            SEQ:     res_bit = zero_fin;
            SLT:     res_bit = lt;
            SLE:     res_bit = lt | zero_fin;
            SCO:     res_bit = s_cout;
            default: res_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Compare ops compute A + ~B + 1; SCO computes plain A + B.
                    op_d    = setop_t'(in_op);
                    a_d     = in_a;
                    b_d     = (setop_t'(in_op) == SCO) ? in_b : ~in_b;
                    carry_d = (setop_t'(in_op) != SCO);
                    zero_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> STEP;
                b_d     = b_q >> STEP;
                carry_d = s_cout;
                zero_d  = zero_q & (s_sum == '0);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(LAST)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = {{(WIDTH-1){1'b0}}, res_bit};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= SEQ;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_serial_set_cond.sv
// Directed bench for serial_set_cond: STEP=1 and STEP=4 instances, vector table plus handshake/reset sequences.
module tb_serial_set_cond;
    import wisc_setcond_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  out_ready;
    logic [15:0] in_a, in_b;
    logic [1:0]  in_op;

    logic        in_ready1, out_valid1, busy1;
    logic [15:0] out_data1;
    logic        in_ready4, out_valid4, busy4;
    logic [15:0] out_data4;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    serial_set_cond #(.WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid1),
        .out_ready(out_ready[0]), .out_data(out_data1), .busy(busy1)
    );

    serial_set_cond #(.WIDTH(16), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
        .out_ready(out_ready[1]), .out_data(out_data4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdy(input int sel);
        return (sel != 0) ? in_ready4 : in_ready1;
    endfunction
    function automatic logic ovld(input int sel);
        return (sel != 0) ? out_valid4 : out_valid1;
    endfunction
    function automatic logic bsy(input int sel);
        return (sel != 0) ? busy4 : busy1;
    endfunction
    function automatic logic [15:0] odat(input int sel);
        return (sel != 0) ? out_data4 : out_data1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Offer one op, count edges from the accept edge (edge 1) until out_valid is seen.
    task automatic run_vec(input int sel, input vec_t v, input int exp_lat);
        int n;
        bit seen;
        string tag;
        tag = $sformatf("%s[step%0d]", v.name, (sel != 0) ? 4 : 1);
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(rdy(sel)), 32'd1);
        in_a = v.a;
        in_b = v.b;
        in_op = v.op;
        in_valid[sel] = 1'b1;
        out_ready[sel] = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                in_valid[sel] = 1'b0;
                check({tag, " busy after accept"}, 32'(bsy(sel)), 32'd1);
            end
            if (ovld(sel)) seen = 1;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " out_data"}, 32'(odat(sel)), 32'(v.exp));
        @(posedge clk);
        #1;
        check({tag, " out_valid drop"}, 32'(ovld(sel)), 32'd0);
        check({tag, " in_ready back"}, 32'(rdy(sel)), 32'd1);
    endtask

    initial begin
        int n;
        bit seen;

        vecs[0]  = '{SLT, 16'h000A, 16'h0005, 16'h0000, "slt_10_5"};
        vecs[1]  = '{SLT, 16'h0005, 16'h000A, 16'h0001, "slt_5_10"};
        vecs[2]  = '{SEQ, 16'h000A, 16'h000A, 16'h0001, "seq_eq"};
        vecs[3]  = '{SLE, 16'h000A, 16'h000A, 16'h0001, "sle_eq"};
        vecs[4]  = '{SLE, 16'hFFFF, 16'hFFFC, 16'h0000, "sle_m1_m4"};
        vecs[5]  = '{SLT, 16'hFFFC, 16'hFFFF, 16'h0001, "slt_m4_m1"};
        vecs[6]  = '{SLT, 16'h8000, 16'h0001, 16'h0001, "slt_min_1"};
        vecs[7]  = '{SLT, 16'h7FFF, 16'h8000, 16'h0000, "slt_max_min"};
        vecs[8]  = '{SCO, 16'hFFFF, 16'h0001, 16'h0001, "sco_carry"};
        vecs[9]  = '{SCO, 16'h7FFF, 16'h0001, 16'h0000, "sco_nocarry"};
        vecs[10] = '{SEQ, 16'h1234, 16'h1235, 16'h0000, "seq_ne"};
        vecs[11] = '{SLE, 16'h0005, 16'h000A, 16'h0001, "sle_lt"};
        vecs[12] = '{SLT, 16'h000A, 16'h000A, 16'h0000, "slt_eq"};
        vecs[13] = '{SCO, 16'h8000, 16'h8000, 16'h0001, "sco_min_min"};
        vecs[14] = '{SEQ, 16'h0000, 16'h0000, 16'h0001, "seq_zero"};
        vecs[15] = '{SLE, 16'h8000, 16'h7FFF, 16'h0001, "sle_min_max"};

        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        in_a = '0;
        in_b = '0;
        in_op = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready1", 32'(in_ready1), 32'd0);
        check("rst out_valid1", 32'(out_valid1), 32'd0);
        check("rst out_data1", 32'(out_data1), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst in_ready4", 32'(in_ready4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-rst in_ready1", 32'(in_ready1), 32'd1);
        check("post-rst in_ready4", 32'(in_ready4), 32'd1);

        for (int i = 0; i < 16; i++) run_vec(0, vecs[i], 17);
        for (int i = 0; i < 16; i++) run_vec(1, vecs[i], 5);

        // Backpressure with a competing offer held through RUN and DONE
        @(negedge clk);
        in_a = 16'h0005; in_b = 16'h000A; in_op = SLT;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        in_a = 16'h0000; in_b = 16'h0000; in_op = SCO;
        n = 1;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 8) check("bp in_ready during run", 32'(in_ready1), 32'd0);
            if (out_valid1) seen = 1;
        end
        check("bp latency", 32'(n), 32'd17);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold out_valid %0d", k), 32'(out_valid1), 32'd1);
            check($sformatf("bp hold out_data %0d", k), 32'(out_data1), 32'd1);
            check($sformatf("bp hold in_ready %0d", k), 32'(in_ready1), 32'd0);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(out_valid1), 32'd0);
        check("bp release in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        check("bp no stale accept busy", 32'(busy1), 32'd0);

        // Reset while RUN at cnt=7
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h0000; in_op = SEQ;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("mid-rst busy before", 32'(busy1), 32'd1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid-rst out_valid", 32'(out_valid1), 32'd0);
        check("mid-rst busy", 32'(busy1), 32'd0);
        check("mid-rst in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid-rst in_ready return", 32'(in_ready1), 32'd1);
        run_vec(0, '{SEQ, 16'h1234, 16'h1234, 16'h0001, "seq_after_rst"}, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/serial_set_cond.md
Name: serial_set_cond

Overview:
- Multi-cycle, handshaked evaluator for the WISC set-condition instructions SEQ, SLT, SLE and SCO on signed 16-bit operands.
- Works as the sequential counterpart to the combinational greater-than comparator. The operand pair is captured once, then processed LSB-first STEP bits per cycle through a serial adder/subtractor, producing the 16-bit set result (0x0000 or 0x0001).
- Sits beside the execute stage as a low-area option for the set-condition path.

Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of STEP.
- STEP, 1: bits processed per compute cycle. Legal values are 1, 2, 4 and 8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand/op offer.
- in_ready  output  1  unit can accept an operand/op.
- in_a  input  WIDTH  operand Rs, two's complement.
- in_b  input  WIDTH  operand Rt, two's complement.
- in_op  input  2  operation select: 00 SEQ, 01 SLT, 10 SLE, 11 SCO.
- out_valid  output  1  result is presented.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result, either 0x0000 or 0x0001.
- busy  output  1  unit is in the RUN state.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state, including mid-RUN or mid-DONE:
  - state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0.
  - All shift registers, carry, zero flag and counter cleared.
  - in_ready goes to 1 on the first edge after rst_n returns high.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a, in_b and in_op.
  - Second operand: latch ~in_b for ops 00/01/10 and in_b for op 11.
  - Initial carry: 1 for ops 00/01/10 and 0 for op 11.
  - Set zero flag=1, cnt=0, then go to RUN.
  - With in_valid low, stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, add STEP low bits of A and B' with the carry, then shift both registers right by STEP.
  - Zero flag &= (sum bits == 0).
  - Update carry; cnt++.
  - On the final slice (cnt == WIDTH/STEP-1), also record the MSB-position carry-in (c_msb), the result sign bit and the final carry-out, then go to DONE.
  - Compute latency is exactly WIDTH/STEP cycles; for the defaults that is 16.
- Result, evaluated on the last RUN edge and registered into out_data:
  - V = c_msb ^ carry_out.
  - SEQ = zero flag.
  - SLT = sign ^ V.
  - SLE = SLT | zero flag.
  - SCO = carry_out of A+B.
  - out_data = {WIDTH-1 zeros, bit}.
- DONE:
  - out_valid=1; out_data is held stable until accepted.
  - On out_ready: out_valid=0, go to IDLE, in_ready=1 on the next cycle.
  - No bypass from DONE to RUN: back-to-back throughput is one op per WIDTH/STEP+2 cycles.
- Total latency: accept edge to out_valid high is WIDTH/STEP+1 cycles. This holds for any out_ready value.
- Input handling:
  - in_valid while in_ready=0 is ignored; the offering side holds it.
  - Input ports are not sampled outside the IDLE accept edge.
- Output handshake: out_ready while out_valid=0 has no effect.
- Wrap-around: overflow cases such as 0x8000 vs 0x0001 are resolved via V, never by raw sign comparison.
- No illegal op values exist, since all four encodings are defined.

Decomposition:
- Shared package wisc_setcond_pkg holds:
  - enum setop_t {SEQ=2'b00, SLT=2'b01, SLE=2'b10, SCO=2'b11}.
  - enum ssc_state_t {IDLE, RUN, DONE}.
  - Function lt_from_flags(sign, v).
- One sub-module, serial_add_slice: a STEP-bit combinational ripple slice with inputs a, b, cin and outputs sum, cout, c_msb.

Test Plan:
- SLT, in_a=0x000A, in_b=0x0005: out_data=0x0000, out_valid rises exactly 17 cycles after accept (defaults). With a=0x0005, b=0x000A: 0x0001.
- SEQ and SLE, a=b=0x000A: SEQ gives 0x0001 and SLE gives 0x0001. SLE with a=0xFFFF (-1), b=0xFFFC (-4) gives 0x0000. SLT with a=0xFFFC, b=0xFFFF gives 0x0001.
- Overflow and carry:
  - SLT with a=0x8000, b=0x0001 gives 0x0001; SLT with a=0x7FFF, b=0x8000 gives 0x0000.
  - SCO with a=0xFFFF, b=0x0001 gives 0x0001; SCO with a=0x7FFF, b=0x0001 gives 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. out_data stays stable and in_ready stays 0. A new in_valid pulse during RUN/DONE is not accepted. After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN: drop rst_n at cnt=7. On the next edge out_valid=0, busy=0, in_ready=0. The following op (SEQ, 0x1234 vs 0x1234) returns 0x0001 with no stale state.
- Parameter sweep STEP=4: repeat scenarios 1-3 and require a latency of 5 cycles with identical results.
